// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit with HI/LO result registers
module muldiv_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hl_sel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             done
);
    localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW   = $clog2(MAXL + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_hi, r_lo, r_a, r_b;
    logic               r_signed, r_done;

    logic               w_mul_op, w_div_op, w_sgn_op;
    logic [2*WIDTH-1:0] w_ext_a, w_ext_b, w_prod;
    logic               w_neg_a, w_neg_b;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_div_b, w_uq, w_ur, w_quo, w_rem;

    assign w_mul_op = (op == 3'd1) || (op == 3'd2);
    assign w_div_op = (op == 3'd3) || (op == 3'd4);
    assign w_sgn_op = (op == 3'd1) || (op == 3'd3);

    // Sign- or zero-extend to 2*WIDTH so one truncated multiply serves both mult and multu
    assign w_ext_a = r_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    assign w_ext_b = r_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // Signed divide via magnitudes; the most-negative / -1 case falls out as quotient 2^(W-1), remainder 0
    assign w_neg_a = r_signed & r_a[WIDTH-1];
    assign w_neg_b = r_signed & r_b[WIDTH-1];
    assign w_abs_a = w_neg_a ? -r_a : r_a;
    assign w_abs_b = w_neg_b ? -r_b : r_b;
    assign w_div_b = (r_b == '0) ? WIDTH'(1) : w_abs_b;
    assign w_uq    = w_abs_a / w_div_b;
    assign w_ur    = w_abs_a % w_div_b;
    assign w_quo   = (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
    assign w_rem   = w_neg_a ? -w_ur : w_ur;

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign rdata = hl_sel ? r_hi : r_lo;
    assign busy  = (r_state != IDLE);
    assign done  = r_done;

    // Control FSM, latency counter and HI/LO writes; flush outranks everything but reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (flush) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else if (r_state == IDLE) begin
                if (start && (w_mul_op || w_div_op)) begin
                    r_a      <= a;
                    r_b      <= b;
                    r_signed <= w_sgn_op;
                    r_state  <= w_mul_op ? MUL : DIV;
                    r_cnt    <= w_mul_op ? CW'(MUL_LAT) : CW'(DIV_LAT);
                end
                if (start && op == 3'd5)
                    r_hi <= a;
                if (start && op == 3'd6)
                    r_lo <= a;
            end else begin
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                    if (r_state == MUL) begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end else if (r_b != '0) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized self-checking bench against an arithmetic HI/LO model
module tb_muldiv_unit;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk = 0, reset = 0, start = 0, flush = 0, hl_sel = 0;
    logic [2:0]  op = 0;
    logic [31:0] a = 0, b = 0;
    logic [31:0] hi, lo, rdata;
    logic        busy, done;

    int n_checks = 0, n_fail = 0;
    logic [31:0] m_hi = 0, m_lo = 0;

    muldiv_unit #(.WIDTH(32), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hl_sel(hl_sel), .hi(hi), .lo(lo), .rdata(rdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Issues one op at the current negedge and checks latency, done, HI/LO and rdata against the model
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sa, sb, p, q, r;
        int n, lat;
        sa = (o == 3'd1 || o == 3'd3) ? longint'($signed(x)) : longint'({32'b0, x});
        sb = (o == 3'd1 || o == 3'd3) ? longint'($signed(y)) : longint'({32'b0, y});
        start = 1; op = o; a = x; b = y; hl_sel = 1'($urandom);
        @(negedge clk);
        start = 0; a = $urandom; b = $urandom;
        if (o == 3'd5) m_hi = x;
        if (o == 3'd6) m_lo = x;
        if (o == 3'd5 || o == 3'd6 || o == 3'd0 || o == 3'd7) begin
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
                n_fail++;
                $display("FAIL move op=%0d: busy=%b done=%b hi=%h lo=%h, want 0 0 hi=%h lo=%h", o, busy, done, hi, lo, m_hi, m_lo);
            end
            return;
        end
        lat = (o <= 3'd2) ? MUL_LAT : DIV_LAT;
        if (o <= 3'd2) begin
            p = sa * sb;
            m_hi = p[63:32]; m_lo = p[31:0];
        end else if (sb != 0) begin
            q = sa / sb; r = sa % sb;
            m_hi = r[31:0]; m_lo = q[31:0];
        end
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL early_done op=%0d: done=%b during busy cycle %0d, want 0", o, done, n + 1);
            end
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (n != lat) begin
            n_fail++;
            $display("FAIL latency op=%0d: busy cycles=%0d, want %0d", o, n, lat);
        end
        n_checks++;
        if (done !== 1'b1 || hi !== m_hi || lo !== m_lo || rdata !== (hl_sel ? m_hi : m_lo)) begin
            n_fail++;
            $display("FAIL result op=%0d a=%h b=%h: done=%b hi=%h lo=%h rdata=%h, want 1 hi=%h lo=%h", o, x, y, done, hi, lo, rdata, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1;
        #3;
        n_checks++;
        if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0) begin
            n_fail++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b, want all 0", hi, lo, busy, done);
        end
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_vectors();
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3);
        n_checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
            n_fail++;
            $display("FAIL mult_vec: hi=%h lo=%h, want ffffffff fffffffa", hi, lo);
        end
        @(negedge clk);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        hl_sel = 1;
        #1;
        n_checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h1 || rdata !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL multu_vec: hi=%h lo=%h rdata=%h, want fffffffe 00000001 fffffffe", hi, lo, rdata);
        end
        @(negedge clk);
        run_op(3'd3, -32'sd7, 32'd2);
        n_checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            n_fail++;
            $display("FAIL div_vec: hi=%h lo=%h, want ffffffff fffffffd", hi, lo);
        end
        @(negedge clk);
        run_op(3'd4, 32'd7, 32'd0);
        n_checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            n_fail++;
            $display("FAIL divu_zero: hi=%h lo=%h, want unchanged ffffffff fffffffd", hi, lo);
        end
        @(negedge clk);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        n_checks++;
        if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL div_ovf: hi=%h lo=%h, want 00000000 80000000", hi, lo);
        end
        @(negedge clk);
        run_op(3'd0, 32'h1111, 32'h2222);
        run_op(3'd7, 32'h3333, 32'h4444);
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x, y;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(1, 6));
            x = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            y = ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
            run_op(o, x, y);
            if ($urandom_range(0, 1)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        run_op(3'd2, 32'd1000, 32'd3000);
        run_op(3'd4, 32'd1000, 32'd7);
        run_op(3'd6, 32'hABCD, 32'h0);
        run_op(3'd1, 32'hFFFF_FFF0, 32'hFFFF_FFF0);
    endtask

    task automatic test_flush();
        @(negedge clk);
        start = 1; op = 3'd3; a = 32'd100; b = 32'd9;
        @(negedge clk);
        op = 3'd5; a = 32'h1234;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        n_checks++;
        if (busy !== 0 || done !== 0 || hi !== m_hi || lo !== m_lo) begin
            n_fail++;
            $display("FAIL flush_mid: busy=%b done=%b hi=%h lo=%h, want 0 0 hi=%h lo=%h", busy, done, hi, lo, m_hi, m_lo);
        end
        start = 1; op = 3'd1; a = 32'd5; b = 32'd6; flush = 1;
        @(negedge clk);
        start = 0; flush = 0;
        n_checks++;
        if (busy !== 0 || done !== 0) begin
            n_fail++;
            $display("FAIL flush_start: busy=%b done=%b, want 0 0", busy, done);
        end
        start = 1; op = 3'd2; a = 32'd77; b = 32'd88;
        @(negedge clk);
        start = 0;
        repeat (MUL_LAT - 1) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        n_checks++;
        if (busy !== 0 || done !== 0 || hi !== m_hi || lo !== m_lo) begin
            n_fail++;
            $display("FAIL flush_last: busy=%b done=%b hi=%h lo=%h, want 0 0 hi=%h lo=%h", busy, done, hi, lo, m_hi, m_lo);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 0 || hi !== m_hi || lo !== m_lo) begin
            n_fail++;
            $display("FAIL flush_late: done=%b hi=%h lo=%h, want 0 hi=%h lo=%h", done, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_mid_reset();
        run_op(3'd6, 32'hDEAD_BEEF, 32'h0);
        start = 1; op = 3'd1; a = 32'd123; b = 32'd456;
        @(negedge clk);
        start = 0;
        @(posedge clk);
        #2 reset = 1;
        #1;
        m_hi = 0; m_lo = 0;
        n_checks++;
        if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0) begin
            n_fail++;
            $display("FAIL mid_reset: hi=%h lo=%h busy=%b done=%b, want all 0", hi, lo, busy, done);
        end
        @(negedge clk);
        reset = 0;
        run_op(3'd6, 32'h55, 32'h0);
        n_checks++;
        if (lo !== 32'h55 || hi !== 32'h0) begin
            n_fail++;
            $display("FAIL mtlo_after_reset: hi=%h lo=%h, want 00000000 00000055", hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_flush();
        test_back_to_back();
        test_random();
        test_mid_reset();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand, HI and LO width (legal range 8..64).
REQ-002 The block SHALL have parameter MUL_LAT, default 5, giving the multiply latency in cycles (legal minimum 1).
REQ-003 The block SHALL have parameter DIV_LAT, default 10, giving the divide latency in cycles (legal minimum 1).
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port start, input, 1 bit: request an operation this cycle.
REQ-007 Port op, input, 3 bits: operation code. 0 = none, 1 = mult, 2 = multu, 3 = div, 4 = divu, 5 = mthi, 6 = mtlo, 7 = reserved (treated as none).
REQ-008 Port a, input, WIDTH bits: operand A (dividend, multiplicand, or mthi/mtlo data).
REQ-009 Port b, input, WIDTH bits: operand B (divisor or multiplier).
REQ-010 Port flush, input, 1 bit: cancel any in-flight operation.
REQ-011 Port hl_sel, input, 1 bit: read select, 1 = HI, 0 = LO.
REQ-012 Port hi, output, WIDTH bits: the HI register.
REQ-013 Port lo, output, WIDTH bits: the LO register.
REQ-014 Port rdata, output, WIDTH bits: combinational hl_sel ? hi : lo.
REQ-015 Port busy, output, 1 bit: an operation is in flight.
REQ-016 Port done, output, 1 bit: one-cycle pulse when HI/LO have just been written by mult/div.

Function
REQ-017 The FSM SHALL have states IDLE, MUL and DIV, plus a down-counter of width ceil(log2(max(MUL_LAT,DIV_LAT)+1)).
REQ-018 In IDLE, start=1 with op 1-2 SHALL latch a and b, load the counter with MUL_LAT, and enter MUL.
REQ-019 In IDLE, start=1 with op 3-4 SHALL latch a and b, load the counter with DIV_LAT, and enter DIV.
REQ-020 busy SHALL be 1 in the MUL and DIV states, i.e. for exactly MUL_LAT or DIV_LAT cycles following the start edge, and 0 otherwise.
REQ-021 The counter SHALL decrement each cycle in MUL/DIV; on the edge where it reaches 0 the block SHALL write HI/LO, return to IDLE, and assert done for the following cycle.
REQ-022 mult/multu SHALL produce a 2*WIDTH-bit product (two's-complement or unsigned respectively) with HI = upper WIDTH bits and LO = lower WIDTH bits.
REQ-023 div/divu SHALL set LO = quotient and HI = remainder; the signed quotient SHALL truncate toward zero and the remainder SHALL take the sign of the dividend.
REQ-024 For signed division of -2^(WIDTH-1) by -1, LO SHALL be -2^(WIDTH-1) and HI SHALL be 0.
REQ-025 For a divisor of 0, the full DIV latency SHALL elapse, done SHALL pulse, and HI/LO SHALL remain unchanged.
REQ-026 In IDLE, start=1 with op 5 (mthi) or 6 (mtlo) SHALL write a into HI or LO on that edge, with no busy and no done.
REQ-027 Any start while busy=1 SHALL be ignored, including mthi/mtlo; the upstream stall logic is responsible for holding the request.
REQ-028 flush=1 SHALL force IDLE on that edge; an in-flight result SHALL be discarded, HI/LO SHALL be left unchanged, and done SHALL not pulse.
REQ-029 When flush=1 and start=1 occur in the same cycle, flush SHALL win and the start SHALL be ignored.
REQ-030 When flush=1 arrives on the completion edge, the write SHALL be suppressed.
REQ-031 Start with op 0 or 7 SHALL be a no-op.
REQ-032 In IDLE, a new start MAY be accepted in the same cycle as done=1, giving back-to-back operations.
REQ-033 Operands SHALL be sampled only on the accept edge; later changes to a and b SHALL not affect the result.

Reset
REQ-034 While reset=1, regardless of clk: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
REQ-035 Reset asserted mid-operation SHALL abort the operation with no HI/LO write.
REQ-036 After reset deasserts, the first rising edge SHALL be able to accept a start.

Verification
REQ-037 WIDTH=32, MUL_LAT=5: mult a=0xFFFFFFFE (-2), b=3 -> busy for 5 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-038 multu a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; hl_sel=1 gives rdata=0xFFFFFFFE.
REQ-039 DIV_LAT=10: div a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1) after 10 busy cycles; divu a=7, b=0 -> hi/lo unchanged, done still pulses.
REQ-040 div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-041 Start div, flush on busy cycle 3 -> busy=0 next cycle, no done, hi/lo unchanged; mthi a=0x1234 while busy -> ignored.
REQ-042 Reset asserted during cycle 2 of mult -> hi=lo=0, busy=0 immediately; mtlo a=0x55 after release -> lo=0x55 on the next edge.
